// File: rtl/tone_write_sequencer.sv
// tone_write_sequencer: master slot counter for the 4-channel DDS tone datapath,
// host write FIFO with slot-safe issue window, and mixed-sample capture.
// Optional build macro: TONE_SEQ_DROP_DETECT_EN (sticky host-write drop flag).
module tone_write_sequencer #(
    parameter int COUNT_MAX  = 1023,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [3:0]  host_addr_in,
    input  logic [15:0] host_data_in,
    input  logic        host_valid_in,
    output logic        host_ready_out,
    output logic [9:0]  master_count_out,
    output logic [3:0]  gen_addr_out,
    output logic [15:0] gen_data_out,
    output logic        gen_valid_out,
    input  logic [15:0] mix_in,
    input  logic        mix_valid_in,
    output logic [15:0] sample_out,
    output logic        sample_strobe_out,
    output logic        frame_start_out,
    output logic        drop_flag_out
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [9:0] CNT_MAX = 10'(COUNT_MAX);
    // Pops are legal only here, so the write lands in slots 17..COUNT_MAX,
    // clear of the phase-update, waveform-latch and mix slots 0..16.
    localparam logic [9:0] WIN_LO = 10'd16;
    localparam logic [9:0] WIN_HI = 10'(COUNT_MAX - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_req_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    wr_req_t          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ, occ_next;
    state_t           state, state_next;
    logic             window_ok, push, pop;

    assign window_ok       = (master_count_out >= WIN_LO) && (master_count_out <= WIN_HI);
    assign push            = host_valid_in && host_ready_out;
    assign frame_start_out = (master_count_out == 10'd0);

    // Free-running slot counter, wraps COUNT_MAX -> 0
    always_ff @(posedge clk_in) begin
        if (reset_in)                     master_count_out <= '0;
        else if (master_count_out == CNT_MAX) master_count_out <= '0;
        else                              master_count_out <= master_count_out + 10'd1;
    end

    // Issue FSM next state; a pop is taken whenever the head is available in the window
    always_comb begin
        state_next = state;
        pop        = (occ != '0) && window_ok;
        case (state)
            IDLE:    if (pop)  state_next = ISSUE;
            ISSUE:   if (!pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign gen_valid_out = (state == ISSUE);

    // FSM state register; reset drops any in-flight issue
    always_ff @(posedge clk_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_next;
    end

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    // FIFO pointers, occupancy and registered ready (not full)
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            host_ready_out <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occ            <= occ_next;
            host_ready_out <= (occ_next != OCC_FULL);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates reads
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: host_addr_in, data: host_data_in};
    end

    // Write bus to the datapath loads the head on pop and holds otherwise
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            gen_addr_out <= '0;
            gen_data_out <= '0;
        end else if (pop) begin
            gen_addr_out <= fifo_mem[rd_ptr].addr;
            gen_data_out <= fifo_mem[rd_ptr].data;
        end
    end

    // Mixed-sample capture; strobe marks the cycle the new sample is visible
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sample_out        <= '0;
            sample_strobe_out <= 1'b0;
        end else begin
            if (mix_valid_in) sample_out <= mix_in;
            sample_strobe_out <= mix_valid_in;
        end
    end

`ifdef TONE_SEQ_DROP_DETECT_EN
    // Sticky flag: host offered a write while the FIFO was full
    always_ff @(posedge clk_in) begin
        if (reset_in)                             drop_flag_out <= 1'b0;
        else if (host_valid_in && !host_ready_out) drop_flag_out <= 1'b1;
    end
`else
    assign drop_flag_out = 1'b0;
`endif

endmodule
